// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch front end: FSM states, the NOP word and
// the {instruction, pc} entry carried through the fetch buffer.
package fetch_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] INST_NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        FLUSH
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0] instruction;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_inst_fifo.sv
// Small synchronous FIFO with flush; holds fetched entries or, with a narrower
// element type, the in-order PC tags of requests still waiting for memory.
module inst_fifo
    import fetch_pkg::*;
#(
    parameter type T     = fetch_entry_t,
    parameter int  DEPTH = 2
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  T                           data_i,
    input  logic                       pop_i,
    output T                           head_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int AW = $clog2(DEPTH);

    T               mem_q [DEPTH];
    logic [AW-1:0]  wr_q;
    logic [AW-1:0]  rd_q;
    logic [AW:0]    cnt_q;
    logic           do_push;
    logic           do_pop;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign do_pop  = pop_i && !empty_o;
    // A full FIFO may still take a push when the head leaves in the same cycle.
    assign do_push = push_i && (!full_o || do_pop);
    assign head_o  = mem_q[rd_q];
    assign count_o = cnt_q;

    always_ff @(posedge clk_i) begin
        if (reset_i || flush_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop)  rd_q <= rd_q + 1'b1;
            cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i && !reset_i) mem_q[wr_q] <= data_i;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: credit-limited in-order word requests, response
// buffering with PC tags, and redirect/reset flushing of stale in-flight work.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
    parameter int              BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] instruction,
    output logic [31:0] inst_pc,
    output logic [31:0] inst_pc_plus4
);

    localparam int CW = $clog2(BUF_DEPTH) + 1;

    fetch_state_t    state_q;
    logic [XLEN-1:0] fetch_pc_q;
    logic [XLEN-1:0] fetch_pc_d;
    logic [CW-1:0]   stale_q;
    logic [CW-1:0]   stale_d;
    logic [CW-1:0]   stale_flush;
    logic [CW-1:0]   inst_cnt;
    logic [CW-1:0]   tag_cnt;
    logic [CW:0]     credit_used;
    logic            inst_full;
    logic            inst_empty;
    logic            tag_full;
    logic            tag_empty;
    fetch_entry_t    inst_head;
    fetch_entry_t    inst_push_entry;
    logic [XLEN-1:0] tag_head;
    logic            req_fire;
    logic            rsp_any;
    logic            rsp_stale;
    logic            rsp_live;
    logic            inst_pop;
    logic            push_ovf;

    // Stale responses still count against the memory-side outstanding limit.
    assign credit_used    = {1'b0, inst_cnt} + {1'b0, tag_cnt} + {1'b0, stale_q};
    assign imem_req_valid = !reset && (state_q == RUN) && !redirect && !tag_full && !inst_full
                            && (credit_used < (CW+1)'(BUF_DEPTH));
    assign imem_req_addr  = fetch_pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // Responses retire stale work first; only then do they match a live PC tag.
    assign rsp_any   = imem_rsp_valid && ((stale_q != '0) || (tag_cnt != '0));
    assign rsp_stale = imem_rsp_valid && (stale_q != '0);
    assign rsp_live  = imem_rsp_valid && (stale_q == '0) && !tag_empty && (state_q == RUN)
                       && !redirect && !reset;

    assign inst_valid      = (state_q == RUN) && !inst_empty;
    assign inst_pop        = inst_valid && inst_ready && !redirect && !reset;
    assign inst_push_entry = '{instruction: imem_rsp_data, pc: tag_head};

    assign instruction   = inst_valid ? inst_head.instruction : INST_NOP;
    assign inst_pc       = inst_valid ? inst_head.pc : fetch_pc_q;
    assign inst_pc_plus4 = inst_pc + 32'd4;

    assign stale_flush = stale_q + tag_cnt - CW'(rsp_any) + CW'(req_fire);

    always_comb begin
        stale_d    = stale_q - CW'(rsp_stale);
        fetch_pc_d = fetch_pc_q;
        if (reset || redirect) stale_d = stale_flush;
        if (redirect)      fetch_pc_d = redirect_pc & ~32'h3;
        else if (req_fire) fetch_pc_d = fetch_pc_q + 32'd4;
    end

    // The stale count deliberately survives reset so that responses to requests
    // issued before reset are still recognised and dropped afterwards.
    always_ff @(posedge clk) begin
        stale_q <= stale_d;
        if (reset) begin
            state_q    <= BOOT;
            fetch_pc_q <= RESET_PC;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            if (redirect) begin
                state_q <= (stale_d != '0) ? FLUSH : RUN;
            end else begin
                case (state_q)
                    BOOT:    state_q <= RUN;
                    RUN:     state_q <= RUN;
                    FLUSH:   if (stale_d == '0) state_q <= RUN;
                    default: state_q <= BOOT;
                endcase
            end
        end
    end

    inst_fifo #(.T(fetch_entry_t), .DEPTH(BUF_DEPTH)) u_inst_q (
        .clk_i   (clk),
        .reset_i (reset),
        .flush_i (redirect),
        .push_i  (rsp_live),
        .data_i  (inst_push_entry),
        .pop_i   (inst_pop),
        .head_o  (inst_head),
        .full_o  (inst_full),
        .empty_o (inst_empty),
        .count_o (inst_cnt)
    );

    inst_fifo #(.T(logic [XLEN-1:0]), .DEPTH(BUF_DEPTH)) u_tag_q (
        .clk_i   (clk),
        .reset_i (reset),
        .flush_i (redirect),
        .push_i  (req_fire),
        .data_i  (fetch_pc_q),
        .pop_i   (rsp_live),
        .head_o  (tag_head),
        .full_o  (tag_full),
        .empty_o (tag_empty),
        .count_o (tag_cnt)
    );

    assign push_ovf = rsp_live && inst_full && !inst_pop;

    a_no_overflow: assert property (@(posedge clk) disable iff (reset) !push_ovf);

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized scoreboard bench for fetch_unit with an in-order variable-latency
// memory model and an expected-PC-stream reference.
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam int          BUF_DEPTH = 2;
    localparam logic [31:0] NOP       = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, rsp_valid, redirect, inst_valid, inst_ready;
    logic [31:0] req_addr, rsp_data, redirect_pc, instruction, inst_pc, inst_pc_plus4;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(RESET_PC), .BUF_DEPTH(BUF_DEPTH)) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (req_valid),
        .imem_req_ready (req_ready),
        .imem_req_addr  (req_addr),
        .imem_rsp_valid (rsp_valid),
        .imem_rsp_data  (rsp_data),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .instruction    (instruction),
        .inst_pc        (inst_pc),
        .inst_pc_plus4  (inst_pc_plus4)
    );

    typedef struct { logic [31:0] addr; int due; } mem_req_t;
    typedef struct { logic [31:0] pc; logic [31:0] word; } exp_t;

    mem_req_t    mem_q[$];
    exp_t        exp_q[$];
    exp_t        e;
    int          checks = 0, errors = 0, cyc = 0, delivered = 0;
    int          lat_min = 1, lat_max = 1;
    logic [31:0] next_pc = RESET_PC;
    logic        prev_reset = 1'b0, prev_redirect = 1'b0, prev_hold = 1'b0;
    logic [31:0] prev_addr = '0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0013;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_max(input string name, input int act, input int lim);
        checks++;
        if (act > lim) begin
            errors++;
            $display("FAIL %s: got %0d allowed at most %0d", name, act, lim);
        end
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        #1;
        reset    = 1'b0;
        redirect = 1'b0;
        if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            rsp_valid = 1'b1;
            rsp_data  = mem_word(mem_q[0].addr);
        end else begin
            rsp_valid = 1'b0;
            rsp_data  = $urandom();
        end
    endtask

    // Monitor: decides at mid-cycle what the next rising edge will commit.
    always @(negedge clk) begin
        if (prev_reset) begin
            chk("rst_req_valid", {31'b0, req_valid}, 32'd0);
            chk("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
            chk("rst_instruction", instruction, NOP);
            chk("rst_inst_pc", inst_pc, RESET_PC);
            chk("rst_pc_plus4", inst_pc_plus4, RESET_PC + 32'd4);
            chk("rst_req_addr", req_addr, RESET_PC);
        end else if (prev_redirect) begin
            chk("inst_valid_after_redirect", {31'b0, inst_valid}, 32'd0);
        end
        if (prev_hold && !reset && !redirect) begin
            chk("hold_req_valid", {31'b0, req_valid}, 32'd1);
            chk("hold_req_addr", req_addr, prev_addr);
        end

        if (rsp_valid && mem_q.size() > 0) void'(mem_q.pop_front());
        if (req_valid && req_ready) begin
            mem_q.push_back('{addr: req_addr, due: cyc + int'($urandom_range(lat_max, lat_min))});
            chk_max("outstanding", mem_q.size(), BUF_DEPTH);
        end

        if (reset) begin
            exp_q.delete();
            next_pc = RESET_PC;
        end else if (redirect) begin
            chk("req_valid_on_redirect", {31'b0, req_valid}, 32'd0);
            exp_q.delete();
            next_pc = redirect_pc & ~32'h3;
        end else begin
            if (inst_valid && inst_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_inst: got pc %h, expected no instruction", inst_pc);
                end else begin
                    e = exp_q.pop_front();
                    chk("inst_pc", inst_pc, e.pc);
                    chk("instruction", instruction, e.word);
                    chk("inst_pc_plus4", inst_pc_plus4, e.pc + 32'd4);
                    delivered++;
                end
            end
            if (req_valid && req_ready) begin
                chk("req_addr", req_addr, next_pc);
                exp_q.push_back('{pc: next_pc, word: mem_word(next_pc)});
                next_pc = next_pc + 32'd4;
                chk_max("live_entries", exp_q.size(), BUF_DEPTH);
            end
        end

        prev_reset    = reset;
        prev_redirect = redirect && !reset;
        prev_hold     = req_valid && !req_ready && !reset && !redirect;
        prev_addr     = req_addr;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int found;
        reset = 1'b1; redirect = 1'b0; redirect_pc = '0;
        req_ready = 1'b1; inst_ready = 1'b1; rsp_valid = 1'b0; rsp_data = '0;
        step(); reset = 1'b1;

        repeat (20) step();

        inst_ready = 1'b0;
        repeat (10) step();
        inst_ready = 1'b1;
        repeat (10) step();

        step(); req_ready = 1'b0;
        repeat (3) step();
        req_ready = 1'b1;
        repeat (10) step();

        // Redirect with two requests in flight and slow memory.
        lat_min = 3; lat_max = 3;
        found = 0;
        for (int i = 0; i < 50 && found == 0; i++) begin
            step();
            if (mem_q.size() == 2) found = 1;
        end
        chk("wait_two_outstanding", found, 1);
        redirect = 1'b1; redirect_pc = 32'h0000_0100;
        repeat (25) step();

        // Misaligned redirect landing on a response and a pop.
        lat_min = 1; lat_max = 1;
        found = 0;
        for (int i = 0; i < 100 && found == 0; i++) begin
            step();
            if (rsp_valid && inst_valid) found = 1;
        end
        chk("wait_rsp_and_pop", found, 1);
        redirect = 1'b1; redirect_pc = 32'h0000_0203; inst_ready = 1'b1;
        repeat (20) step();

        // Address wrap at the top of the address space.
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8;
        repeat (20) step();

        // Reset with one request outstanding to slow memory.
        lat_min = 3; lat_max = 3;
        found = 0;
        for (int i = 0; i < 50 && found == 0; i++) begin
            step();
            if (mem_q.size() == 1) found = 1;
        end
        chk("wait_one_outstanding", found, 1);
        reset = 1'b1;
        repeat (30) step();

        lat_min = 1; lat_max = 4;
        for (int i = 0; i < 1500; i++) begin
            step();
            req_ready  = ($urandom_range(0, 3) != 0);
            inst_ready = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 31) == 0) begin
                redirect    = 1'b1;
                redirect_pc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom() & 32'hF))
                                                         : $urandom();
            end
            if ($urandom_range(0, 199) == 0) reset = 1'b1;
        end

        req_ready = 1'b1; inst_ready = 1'b1;
        repeat (40) step();

        checks++;
        if (delivered < 100) begin
            errors++;
            $display("FAIL delivered_count: got %0d need at least 100", delivered);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
